// File: rtl/irig_time_uart_packer_pkg.sv
// rtl/irig_time_uart_packer_pkg.sv - shared constants, state type and checksum for the IRIG time packer
package irig_time_uart_packer_pkg;

    localparam logic [7:0] PKT_HDR0 = 8'hAA;
    localparam logic [7:0] PKT_HDR1 = 8'h55;
    localparam int         PKT_LEN  = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Mod-256 sum of payload bytes B2..B7.
    function automatic logic [7:0] pkt_checksum(
        input logic [7:0]  sec,
        input logic [7:0]  min,
        input logic [7:0]  hour,
        input logic [11:0] day,
        input logic [7:0]  year
    );
        logic [7:0] sum;
        sum = sec + min + hour + day[7:0] + {4'h0, day[11:8]} + year;
        return sum;
    endfunction

endpackage

// File: rtl/irig_time_uart_packer_if.sv
// rtl/irig_time_uart_packer_if.sv - time-stamp input and UART feeder output bundle
interface irig_time_uart_packer_if;

    logic        time_valid;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic [7:0]  hour_bcd;
    logic [11:0] day_bcd;
    logic [7:0]  year_bcd;
    logic [7:0]  tx_data;
    logic        tx_flag;
    logic        busy;
    logic        pkt_done;
    logic        pkt_drop;

    modport master (
        output time_valid, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd,
        input  tx_data, tx_flag, busy, pkt_done, pkt_drop
    );

    modport slave (
        input  time_valid, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd,
        output tx_data, tx_flag, busy, pkt_done, pkt_drop
    );

endinterface

// File: rtl/irig_time_uart_packer_byte_pacer.sv
// rtl/irig_time_uart_packer_byte_pacer.sv - launch-to-launch spacing down-counter
module irig_time_uart_packer_byte_pacer #(
    parameter int BYTE_GAP = 110
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic expire_o
);

    localparam int W = $clog2(BYTE_GAP);

    logic [W-1:0] cnt_q;

    // Loaded in the launch cycle; expires on the last gap cycle so launches sit BYTE_GAP apart.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= W'(BYTE_GAP - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire_o = (cnt_q == W'(1)) && !start_i;

endmodule

// File: rtl/irig_time_uart_packer.sv
// rtl/irig_time_uart_packer.sv - snapshots an IRIG-B time stamp and paces it out as a 9-byte UART packet
module irig_time_uart_packer
    import irig_time_uart_packer_pkg::*;
#(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000,
    parameter int GAP_BITS = 11
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    irig_time_uart_packer_if.slave   bus
);

    localparam int BYTE_GAP = (CLK_FREQ / UART_BPS) * GAP_BITS;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [7:0]  sec_q, min_q, hour_q, year_q, chk_q;
    logic [11:0] day_q;
    logic [7:0]  tx_data_q;
    logic        tx_flag_q, busy_q, pkt_done_q, pkt_drop_q;
    logic        gap_expire;
    logic [3:0]  idx_nx;
    logic [7:0]  byte_nx;

    irig_time_uart_packer_byte_pacer #(.BYTE_GAP(BYTE_GAP)) u_pacer (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .start_i  (state_q == LAUNCH),
        .expire_o (gap_expire)
    );

    // Byte that the next launch will present, taken from the snapshot.
    always_comb begin
        idx_nx  = idx_q + 4'd1;
        byte_nx = PKT_HDR0;
        case (idx_nx)
            4'd1:    byte_nx = PKT_HDR1;
            4'd2:    byte_nx = sec_q;
            4'd3:    byte_nx = min_q;
            4'd4:    byte_nx = hour_q;
            4'd5:    byte_nx = day_q[7:0];
            4'd6:    byte_nx = {4'h0, day_q[11:8]};
            4'd7:    byte_nx = year_q;
            4'd8:    byte_nx = chk_q;
            default: byte_nx = PKT_HDR0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            day_q      <= '0;
            year_q     <= '0;
            chk_q      <= '0;
            tx_data_q  <= '0;
            tx_flag_q  <= 1'b0;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_drop_q <= 1'b0;
        end else begin
            tx_flag_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.time_valid) begin
                        sec_q     <= bus.sec_bcd;
                        min_q     <= bus.min_bcd;
                        hour_q    <= bus.hour_bcd;
                        day_q     <= bus.day_bcd;
                        year_q    <= bus.year_bcd;
                        chk_q     <= pkt_checksum(bus.sec_bcd, bus.min_bcd, bus.hour_bcd,
                                                  bus.day_bcd, bus.year_bcd);
                        idx_q     <= '0;
                        tx_data_q <= PKT_HDR0;
                        tx_flag_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    pkt_drop_q <= bus.time_valid;
                    state_q    <= GAP;
                end
                GAP: begin
                    pkt_drop_q <= bus.time_valid;
                    if (gap_expire) begin
                        if (idx_q < 4'(PKT_LEN - 1)) begin
                            idx_q     <= idx_nx;
                            tx_data_q <= byte_nx;
                            tx_flag_q <= 1'b1;
                            state_q   <= LAUNCH;
                        end else begin
                            idx_q      <= '0;
                            busy_q     <= 1'b0;
                            pkt_done_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_flag  = tx_flag_q;
    assign bus.busy     = busy_q;
    assign bus.pkt_done = pkt_done_q;
    assign bus.pkt_drop = pkt_drop_q;

endmodule
